// File: rtl/temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// temp_fan_ctrl
//   Autonomous reader for the board temperature sensor SPI port and fan driver.
//   A frame is started by the poll timer or by a start pulse. Each frame drops
//   chip select, clocks 16 bits in MSB first, publishes the 14-bit signed
//   temperature (LSB = 1/32 degC) and updates the fan with on/off hysteresis.
//
// Ports
//   clk         system clock (50 MHz on the SoCKit board)
//   reset_n     asynchronous, active-low reset
//   start       one-cycle request for an immediate read (ignored while busy)
//   fan_force   holds fan_ctrl high while asserted
//   temp_dout   sensor serial data
//   temp_cs_n   sensor chip select, active low
//   temp_sclk   sensor serial clock, idle high
//   temp_din    sensor serial input, constant 0 (normal-mode control word)
//   temp_value  last temperature, two's complement, 1/32 degC
//   temp_valid  one-cycle pulse when temp_value updates
//   busy        high while a frame is in progress
//   fan_ctrl    fan enable, fail-safe high until the first reading
// -----------------------------------------------------------------------------
module temp_fan_ctrl #(
    parameter int CLK_DIV      = 25,        // clk cycles per SCLK half-period, 1..255
    parameter int POLL_CYCLES  = 50000000,  // clk cycles between automatic reads
    parameter int FAN_ON_TEMP  = 1440,      // 45.0 degC
    parameter int FAN_OFF_TEMP = 1280       // 40.0 degC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        fan_force,
    input  logic        temp_dout,
    output logic        temp_cs_n,
    output logic        temp_sclk,
    output logic        temp_din,
    output logic [13:0] temp_value,
    output logic        temp_valid,
    output logic        busy,
    output logic        fan_ctrl
);

    localparam int                     CNT_W      = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
    localparam logic [7:0]             DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic signed [13:0]     ON_THRESH  = 14'(FAN_ON_TEMP);
    localparam logic signed [13:0]     OFF_THRESH = 14'(FAN_OFF_TEMP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_UPDATE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] period_cnt;
    logic [7:0]       div_cnt;
    logic [3:0]       bit_cnt;
    // Only the temperature field is kept: the first two bits of the frame
    // (bits 15:14) shift out of the top before the frame ends.
    logic [13:0]      shift_reg;
    logic             fan_on;

    logic             div_done;
    logic             trigger;
    logic             sclk_next;
    logic             sample;
    logic             frame_done;

    assign temp_din = 1'b0;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        div_done   = (div_cnt == DIV_LAST);
        trigger    = (period_cnt == POLL_LAST) || start;
        next_state = state;
        sclk_next  = temp_sclk;
        sample     = 1'b0;
        frame_done = 1'b0;

        case (state)
            S_IDLE: begin
                if (trigger) begin
                    next_state = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (div_done) begin
                    next_state = S_SHIFT;
                    sclk_next  = 1'b0;
                end
            end
            S_SHIFT: begin
                if (div_done) begin
                    if (!temp_sclk) begin
                        // Rising SCLK edge: data launched on the falling edge is stable.
                        sclk_next = 1'b1;
                        sample    = 1'b1;
                    end else if (bit_cnt == 4'd15) begin
                        // 16th high half-period done; SCLK stays high into CS_HOLD.
                        next_state = S_CS_HOLD;
                    end else begin
                        sclk_next = 1'b0;
                    end
                end
            end
            S_CS_HOLD: begin
                if (div_done) begin
                    next_state = S_UPDATE;
                    frame_done = 1'b1;
                end
            end
            S_UPDATE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            temp_cs_n  <= 1'b1;
            temp_sclk  <= 1'b1;
            temp_value <= '0;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
            fan_on     <= 1'b1;
            fan_ctrl   <= 1'b1;
        end else begin
            // The poll timer keeps running through a frame and restarts at
            // each frame start, so automatic reads are POLL_CYCLES apart
            // start-to-start. A trigger is only honoured in IDLE.
            if (state == S_IDLE && trigger) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + CNT_W'(1);
            end

            if (state == S_IDLE || state == S_UPDATE || div_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (state == S_IDLE) begin
                bit_cnt <= '0;
            end else if (state == S_SHIFT && div_done && temp_sclk) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (sample) begin
                shift_reg <= {shift_reg[12:0], temp_dout};
            end

            temp_sclk  <= sclk_next;
            temp_cs_n  <= !(next_state inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
            busy       <= (next_state != S_IDLE);
            temp_valid <= frame_done;

            if (frame_done) begin
                temp_value <= shift_reg;
                if ($signed(shift_reg) >= ON_THRESH) begin
                    fan_on <= 1'b1;
                end else if ($signed(shift_reg) <= OFF_THRESH) begin
                    fan_on <= 1'b0;
                end
            end

            fan_ctrl <= fan_on | fan_force;
        end
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_fan_ctrl
//   Directed and randomized bench for temp_fan_ctrl with CLK_DIV=2 and
//   POLL_CYCLES=200. A sensor model shifts a programmed word out on SCLK
//   falling edges; expected temperatures and fan state come from the
//   hysteresis rules applied to plain integers.
// -----------------------------------------------------------------------------
module tb_temp_fan_ctrl;

    localparam int CLK_DIV   = 2;
    localparam int POLL      = 200;
    localparam int ON_T      = 1440;
    localparam int OFF_T     = 1280;
    localparam int VALID_CYC = 34 * CLK_DIV + 1;
    localparam int WINDOW    = 90;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        fan_force = 1'b0;
    logic        temp_dout = 1'b0;
    logic        temp_cs_n;
    logic        temp_sclk;
    logic        temp_din;
    logic [13:0] temp_value;
    logic        temp_valid;
    logic        busy;
    logic        fan_ctrl;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sensor_word = 16'h0640;
    int          bit_idx  = 15;
    int          rise_cnt = 0;
    bit          model_fan = 1'b1;

    temp_fan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .POLL_CYCLES  (POLL),
        .FAN_ON_TEMP  (ON_T),
        .FAN_OFF_TEMP (OFF_T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .fan_force  (fan_force),
        .temp_dout  (temp_dout),
        .temp_cs_n  (temp_cs_n),
        .temp_sclk  (temp_sclk),
        .temp_din   (temp_din),
        .temp_value (temp_value),
        .temp_valid (temp_valid),
        .busy       (busy),
        .fan_ctrl   (fan_ctrl)
    );

    always #5 clk = ~clk;

    // Sensor: chip select restarts the word; each SCLK fall presents the next bit.
    always @(negedge temp_cs_n or negedge temp_sclk) begin
        if (temp_sclk) begin
            bit_idx = 15;
        end else if (!temp_cs_n && bit_idx >= 0) begin
            temp_dout = sensor_word[bit_idx];
            bit_idx   = bit_idx - 1;
        end
    end

    always @(posedge temp_sclk) rise_cnt = rise_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed14(input logic [13:0] v);
        int r;
        r = int'(v);
        if (r >= 8192) r = r - 16384;
        return r;
    endfunction

    task automatic model_update(input int t);
        if (t >= ON_T) model_fan = 1'b1;
        else if (t <= OFF_T) model_fan = 1'b0;
    endtask

    // Starts a frame from a negedge in IDLE and watches WINDOW cycles after
    // the start edge. Cycle k is the interval after the k-th edge (start edge = 0).
    task automatic do_frame(input logic [15:0] word, input bit extra_starts,
                            output int valid_cyc, output int busy_first,
                            output int busy_last, output int pulses,
                            output logic [13:0] val);
        valid_cyc  = -1;
        busy_first = -1;
        busy_last  = -1;
        pulses     = 0;
        val        = 'x;
        sensor_word = word;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= WINDOW; k++) begin
            @(negedge clk);
            start = extra_starts && (k == 10 || k == 30);
            if (temp_valid === 1'b1) begin
                pulses = pulses + 1;
                if (valid_cyc < 0) begin
                    valid_cyc = k;
                    val       = temp_value;
                end
            end
            if (busy === 1'b1) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic read_check(input logic [15:0] word, input string tag);
        int          vc, bf, bl, np;
        logic [13:0] val;
        do_frame(word, 1'b0, vc, bf, bl, np, val);
        model_update(to_signed14(word[13:0]));
        check({tag, " valid_cycle"}, vc, VALID_CYC);
        check({tag, " value"}, val, word[13:0]);
        check({tag, " fan_ctrl"}, fan_ctrl, model_fan);
    endtask

    initial begin
        int          edges;
        int          pulses;
        int          frame_rises;
        int          rise_base;
        int          vc, bf, bl, np;
        bit          seen_high;
        logic [13:0] val;
        logic [15:0] w;
        int          t;
        int          hi;

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cs_n", temp_cs_n, 1'b1);
        check("rst sclk", temp_sclk, 1'b1);
        check("rst din", temp_din, 1'b0);
        check("rst value", temp_value, 14'd0);
        check("rst valid", temp_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst fan_ctrl", fan_ctrl, 1'b1);

        // Automatic polling after release
        reset_n   = 1'b1;
        rise_base = rise_cnt;
        edges     = 0;
        while (temp_cs_n === 1'b1 && edges < 2 * POLL) begin
            @(posedge clk);
            edges = edges + 1;
            @(negedge clk);
        end
        check("first_frame_delay", edges, POLL);
        check("idle sclk rises", rise_cnt - rise_base, 0);
        check("idle fan_ctrl", fan_ctrl, 1'b1);

        edges       = 0;
        seen_high   = 1'b0;
        pulses      = 0;
        frame_rises = -1;
        val         = 'x;
        while (edges < 2 * POLL) begin
            @(posedge clk);
            edges = edges + 1;
            @(negedge clk);
            if (temp_valid === 1'b1) begin
                pulses = pulses + 1;
                val    = temp_value;
            end
            if (temp_cs_n === 1'b1) begin
                if (!seen_high) begin
                    seen_high   = 1'b1;
                    frame_rises = rise_cnt - rise_base;
                end
            end else if (seen_high) begin
                break;
            end
        end
        check("poll_period", edges, POLL);
        check("auto sclk rises", frame_rises, 16);
        check("auto pulses", pulses, 1);
        check("auto value", val, 14'h0640);
        model_update(to_signed14(14'h0640));

        edges = 0;
        while (busy === 1'b1 && edges < 2 * POLL) begin
            @(negedge clk);
            edges = edges + 1;
        end
        check("auto2 done", busy, 1'b0);
        check("auto fan_ctrl", fan_ctrl, model_fan);

        // On-demand read at the on-threshold
        rise_base = rise_cnt;
        do_frame(16'h05A0, 1'b0, vc, bf, bl, np, val);
        model_update(to_signed14(14'h05A0));
        check("start valid_cycle", vc, VALID_CYC);
        check("start value", val, 14'h05A0);
        check("start busy_first", bf, 1);
        check("start busy_last", bl, VALID_CYC);
        check("start pulses", np, 1);
        check("start sclk rises", rise_cnt - rise_base, 16);
        check("start fan_ctrl", fan_ctrl, 1'b1);

        // Hysteresis around the thresholds
        read_check(16'd1300, "hyst_1300");
        read_check(16'd1280, "hyst_1280");
        read_check(16'd1400, "hyst_1400");
        read_check(16'd1440, "hyst_1440");

        // Negative reading with junk in bits 15:14
        read_check(16'hFFE0, "neg_ffe0");
        check("neg value literal", temp_value, 14'h3FE0);
        check("neg fan literal", fan_ctrl, 1'b0);

        // Starts during a frame are ignored
        read_check(16'd1500, "pre_ignore");
        do_frame(16'd1000, 1'b1, vc, bf, bl, np, val);
        model_update(to_signed14(14'd1000));
        check("ignore pulses", np, 1);
        check("ignore busy_last", bl, VALID_CYC);
        check("ignore value", val, 14'd1000);
        check("ignore fan_ctrl", fan_ctrl, model_fan);

        // Asynchronous reset in the middle of SHIFT
        sensor_word = 16'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("midframe cs_n", temp_cs_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("async cs_n", temp_cs_n, 1'b1);
        check("async sclk", temp_sclk, 1'b1);
        check("async value", temp_value, 14'd0);
        check("async fan_ctrl", fan_ctrl, 1'b1);
        check("async busy", busy, 1'b0);
        check("async valid", temp_valid, 1'b0);
        model_fan = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (temp_valid === 1'b1) pulses = pulses + 1;
        end
        check("post_reset pulses", pulses, 0);
        check("post_reset value", temp_value, 14'd0);

        // fan_force with the fan off
        read_check(16'd1000, "force_pre");
        @(negedge clk);
        fan_force = 1'b1;
        #1 check("force immediate", fan_ctrl, 1'b0);
        @(negedge clk);
        check("force on", fan_ctrl, 1'b1);
        fan_force = 1'b0;
        #1 check("release immediate", fan_ctrl, 1'b1);
        @(negedge clk);
        check("force off", fan_ctrl, 1'b0);

        // Randomized readings, mostly near the thresholds
        for (int i = 0; i < 10; i++) begin
            if (i % 4 == 3) begin
                w = 16'($urandom);
            end else begin
                t  = int'($urandom_range(1200, 1520));
                hi = int'($urandom_range(0, 3));
                w  = {2'(hi), 14'(t)};
            end
            read_check(w, $sformatf("rand%0d_%04h", i, w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/temp_fan_ctrl.md
Name: temp_fan_ctrl

Overview:
- Autonomous controller for the board temperature sensor SPI port (TEMP_CS_n/TEMP_SCLK/TEMP_DIN/TEMP_DOUT) and the FAN_CTRL output.
- Polls the sensor periodically or on demand, reads one 16-bit frame, and publishes the 14-bit signed temperature.
- Drives the fan with on/off hysteresis.
- Instantiated in the SoCKit top level on the 50 MHz OSC_50_B5B clock, alongside the soc_system instance.

Parameters:
- CLK_DIV, 25: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz); legal range 1..255.
- POLL_CYCLES, 50000000: clk cycles between automatic reads; must exceed 34*CLK_DIV+2.
- FAN_ON_TEMP, 1440: signed 14-bit threshold, LSB = 1/32 degC (45.0 degC); fan turns on at or above this value.
- FAN_OFF_TEMP, 1280: signed 14-bit threshold (40.0 degC); fan turns off at or below this value; must be < FAN_ON_TEMP.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request for an immediate read.
- fan_force  in  1  forces fan_ctrl high while asserted.
- temp_dout  in  1  sensor serial data (TEMP_DOUT).
- temp_cs_n  out  1  sensor chip select (TEMP_CS_n).
- temp_sclk  out  1  sensor serial clock (TEMP_SCLK).
- temp_din  out  1  sensor serial input (TEMP_DIN).
- temp_value  out  14  last temperature, two's complement, 1/32 degC.
- temp_valid  out  1  one-cycle pulse when temp_value updates.
- busy  out  1  high while a frame is in progress.
- fan_ctrl  out  1  fan enable (FAN_CTRL).

Behaviour:
- All outputs are registered.
- Reset values:
  - temp_cs_n=1, temp_sclk=1, temp_din=0, temp_value=0, temp_valid=0, busy=0.
  - Internal fan_on=1, so fan_ctrl=1 (fail-safe on until the first reading).
  - Period counter=0; FSM=IDLE.
- temp_din is constant 0 (normal-mode control word).
- Period counter:
  - Increments in IDLE.
  - Trigger condition: (count==POLL_CYCLES-1) OR start, sampled in IDLE.
  - Counter clears to 0 on every frame start.
  - start and tick in the same cycle produce one frame.
  - start while busy is ignored, not queued.
- FSM:
  - IDLE: on trigger go to CS_SETUP. From the next cycle, busy=1 and cs_n=0.
  - CS_SETUP: CLK_DIV cycles with sclk=1, then SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - temp_dout is sampled into a 16-bit shift register, MSB first, on the clk edge where sclk goes 0->1.
    - After the 16th high half-period, go to CS_HOLD.
  - CS_HOLD: CLK_DIV cycles with cs_n=0, sclk=1. Then cs_n=1 and go to UPDATE.
  - UPDATE (1 cycle):
    - temp_value <= shift[13:0]; shift[15:14] are ignored.
    - temp_valid=1.
    - Fan decision uses the new value.
    - Next state IDLE, busy=0.
- Latency: if start is sampled at cycle 0, temp_valid is high at cycle 34*CLK_DIV+1 and busy falls the cycle after.
- SCLK is idle-high. Exactly 16 rising edges occur per frame, none outside CS_SETUP..CS_HOLD.
- Fan hysteresis (signed compare):
  - new >= FAN_ON_TEMP -> fan_on=1.
  - new <= FAN_OFF_TEMP -> fan_on=0.
  - Otherwise hold.
  - fan_ctrl = fan_on | fan_force, registered (1-cycle latency from fan_force or UPDATE).
- Reset asserted mid-frame: all outputs take reset values immediately (async). The partial frame is discarded and temp_valid is not pulsed.
- Counter width: $clog2(POLL_CYCLES). CLK_DIV counter width: 8 bits.

Test Plan:
All scenarios use CLK_DIV=2, POLL_CYCLES=200, default thresholds, and a sensor model that shifts out a programmed 16-bit word on SCLK falling edges.
1. Release reset, start=0:
   - Outputs hold reset values; fan_ctrl=1.
   - First cs_n fall occurs 200 cycles after release.
   - Exactly 16 sclk rising edges occur; next frame starts 200 cycles after the previous start.
2. start pulse, model word 16'h05A0:
   - temp_valid at cycle 69 after start; temp_value=14'h05A0 (1440).
   - fan_ctrl stays 1; busy high cycles 1..69.
3. Successive reads of 1300, 1280, 1400, 1440:
   - fan_ctrl after each read = 1, 0, 0, 1 (hysteresis held between thresholds).
4. Model word 16'hFFE0 after fan turned on:
   - temp_value=14'h3FE0 (-1 degC); fan_ctrl=0 (signed compare); bits 15:14 ignored.
5. start pulses at cycles 10 and 30 of a frame:
   - Ignored; exactly one temp_valid per frame.
   - reset_n low mid-SHIFT gives cs_n=1, sclk=1, temp_value=0, fan_ctrl=1 in the same cycle, with no temp_valid.
6. fan_force=1 with fan_on=0:
   - fan_ctrl=1 one cycle later; fan_force=0 returns fan_ctrl to 0 one cycle later.
